alu181_seq: RTL and testbench
=============================

Name: alu181_seq

Overview:
- Parametrised, nibble-serial successor to the team's 4-bit 74181-style ALU slice.
- Implements the full 32-function 74181 set (16 logic when M=1, 16 arithmetic when M=0) on WIDTH-bit operands.
- Processes NIB_PER_CYC nibbles per clock, holding the inter-nibble carry in a register.
- Sits behind a valid/ready handshake so datapath sequencers can issue multi-cycle ALU ops without a wide combinational carry chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4*NIB_PER_CYC (elaboration error otherwise).
- NIB_PER_CYC, 1, nibbles evaluated per clock; NSTEP = WIDTH/(4*NIB_PER_CYC).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an op.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- s_i  in  4  function select S[3:0].
- m_i  in  1  1 = logic, 0 = arithmetic.
- cin_i  in  1  carry-in, active-high (+1).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- f_o  out  WIDTH  result F.
- cout_o  out  1  carry out of bit WIDTH-1 (arithmetic only, 0 when m=1).
- aeqb_o  out  1  F is all ones.
- grp_p_o  out  1  group propagate, &U.
- grp_g_o  out  1  group generate (carry out with cin=0).
- ovf_o  out  1  signed overflow (see Optional Feature).

Behaviour:
- Per-bit terms:
  - U = A | (B & S0) | (~B & S1)
  - V = (A & B & S3) | (A & ~B & S2)
- Arithmetic (m=0): F = U + V + cin, modulo 2^WIDTH; cout = bit WIDTH of that sum. Yields A+B at S=9, A-B-1 at S=6, -1 (all ones) at S=3, A-1 at S=15.
- Logic (m=1): F = ~(U ^ V); cout = 0. Yields ~A at S=0, A^B at S=6, ~(A^B) at S=9, A&B at S=11, A at S=15.
- grp_g: carry out of U+V with zero carry-in, m-independent.
- aeqb: computed from the final F.
- FSM states:
  - IDLE: in_ready=1. in_valid=1 latches a, b, s, m, cin; carry reg <= cin; step <= 0; go RUN.
  - RUN: each cycle evaluates NIB_PER_CYC nibbles (LSB first) using the carry reg. Writes F nibbles and updates carry, grp_p and grp_g accumulators. step increments. After step NSTEP-1 completes, go DONE.
  - DONE: out_valid=1, all outputs stable. out_ready=1 returns to IDLE the same edge.
- Latency: op accepted at edge k gives out_valid=1 after edge k+NSTEP.
- in_ready=0 in RUN and DONE; no overlap of ops.
- in_valid while not IDLE is ignored; the producer must hold it.
- Outputs may be X-free but meaningless outside DONE; the bench checks only in DONE.
- Reset (any state, including mid-RUN): state=IDLE; f_o=0, cout_o=0, aeqb_o=0, grp_p_o=0, grp_g_o=0, ovf_o=0, out_valid=0, in_ready=1. A partial op is discarded.
- NIB_PER_CYC = WIDTH/4 gives a single-cycle RUN (NSTEP=1).

Optional Feature:
- Macro ALU181_OVF_EN.
- Defined: carry into the MSB is tracked; ovf_o = carry_into_msb ^ cout in arithmetic mode, 0 in logic mode; valid in DONE.
- Undefined: ovf_o tied 0, no extra state.

Test Plan:
- WIDTH=16, NIB_PER_CYC=1; m=0 s=9 cin=0 a=0x1234 b=0x0FFF -> f=0x2233, cout=0; out_valid 4 cycles after accept.
- m=0 s=6 cin=1 a=0x0005 b=0x0007 -> f=0xFFFE, cout=0. Repeat with a=b=0x1234 cin=0 -> f=0xFFFF, aeqb=1.
- m=1 s=6 a=0xF0F0 b=0xFF00 -> f=0x0FF0, cout=0, aeqb=0. Then s=3 -> f=0x0000.
- m=0 s=9 cin=1 a=0xFFFF b=0x0000 -> f=0x0000, cout=1, grp_p=1, grp_g=0. With ALU181_OVF_EN: a=0x7FFF b=0x0001 cin=0 -> f=0x8000, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> f/flags stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next edge.
- Assert rst 2 cycles into RUN -> all outputs 0, in_ready=1 immediately. Next op completes correctly with no stale carry.

Source files
------------

// File: rtl/alu181_seq.sv
// alu181_seq: nibble-serial 74181-style ALU behind a valid/ready handshake.
// Define ALU181_OVF_EN to produce a signed-overflow flag; otherwise ovf_o is tied 0.
module alu181_seq #(
    parameter int WIDTH       = 16,
    parameter int NIB_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       s_i,
    input  logic             m_i,
    input  logic             cin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             aeqb_o,
    output logic             grp_p_o,
    output logic             grp_g_o,
    output logic             ovf_o
);
    localparam int CW    = 4 * NIB_PER_CYC;
    localparam int NSTEP = WIDTH / CW;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (NIB_PER_CYC < 1 || WIDTH < CW || (WIDTH % CW) != 0) begin : g_bad_cfg
            $error("alu181_seq: WIDTH must be a nonzero multiple of 4*NIB_PER_CYC");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, f_q;
    logic [3:0]       s_q;
    logic             m_q, c_q, g_q, p_q;
    logic [SW-1:0]    step_q;
    logic             in_ready_q, out_valid_q, cout_q, aeqb_q, grp_p_q, grp_g_q;

    logic [CW-1:0]       u, v, f_sl, a_sl, b_sl;
    logic [CW:0]         sum, gsum;
    logic [WIDTH+CW-1:0] f_cat;
    logic [WIDTH-1:0]    f_d;
    logic                last;

    always_comb begin
        a_sl  = a_q[CW-1:0];
        b_sl  = b_q[CW-1:0];
        u     = a_sl | (b_sl & {CW{s_q[0]}}) | (~b_sl & {CW{s_q[1]}});
        v     = (a_sl & b_sl & {CW{s_q[3]}}) | (a_sl & ~b_sl & {CW{s_q[2]}});
        sum   = {1'b0, u} + {1'b0, v} + {{CW{1'b0}}, c_q};
        gsum  = {1'b0, u} + {1'b0, v} + {{CW{1'b0}}, g_q};
        f_sl  = m_q ? ~(u ^ v) : sum[CW-1:0];
        // result fills from the top so the first (LSB) slice ends up at bit 0
        f_cat = {f_sl, f_q};
        f_d   = f_cat[WIDTH+CW-1:CW];
        last  = step_q == SW'(NSTEP - 1);
    end

`ifdef ALU181_OVF_EN
    logic [CW-1:0] lo;
    logic          ovf_q;

    always_comb begin
        lo = {1'b0, u[CW-2:0]} + {1'b0, v[CW-2:0]} + {{(CW-1){1'b0}}, c_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (state_q == RUN && last)
            ovf_q <= ~m_q & (lo[CW-1] ^ sum[CW]);
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            c_q         <= 1'b0;
            g_q         <= 1'b0;
            p_q         <= 1'b0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            aeqb_q      <= 1'b0;
            grp_p_q     <= 1'b0;
            grp_g_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a_i;
                    b_q        <= b_i;
                    s_q        <= s_i;
                    m_q        <= m_i;
                    c_q        <= cin_i;
                    g_q        <= 1'b0;
                    p_q        <= 1'b1;
                    step_q     <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    a_q    <= a_q >> CW;
                    b_q    <= b_q >> CW;
                    c_q    <= sum[CW];
                    g_q    <= gsum[CW];
                    p_q    <= p_q & (&u);
                    f_q    <= f_d;
                    step_q <= step_q + 1'b1;
                    if (last) begin
                        cout_q      <= ~m_q & sum[CW];
                        grp_g_q     <= gsum[CW];
                        grp_p_q     <= p_q & (&u);
                        aeqb_q      <= &f_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f_o       = f_q;
    assign cout_o    = cout_q;
    assign aeqb_o    = aeqb_q;
    assign grp_p_o   = grp_p_q;
    assign grp_g_o   = grp_g_q;
endmodule

// File: tb/tb_alu181_seq.sv
// tb_alu181_seq: directed vectors for alu181_seq, checked against a full-width arithmetic model.
module tb_alu181_seq;
    logic        clk, rst, in_valid, in_ready, m_i, cin_i, out_valid, out_ready;
    logic [15:0] a_i, b_i, f_o;
    logic [3:0]  s_i;
    logic        cout_o, aeqb_o, grp_p_o, grp_g_o, ovf_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] op_a, op_b;
    logic [3:0]  op_s;
    logic        op_m, op_cin;

    alu181_seq #(.WIDTH(16), .NIB_PER_CYC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a_i), .b_i(b_i), .s_i(s_i), .m_i(m_i), .cin_i(cin_i),
        .out_valid(out_valid), .out_ready(out_ready), .f_o(f_o),
        .cout_o(cout_o), .aeqb_o(aeqb_o), .grp_p_o(grp_p_o),
        .grp_g_o(grp_g_o), .ovf_o(ovf_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Whole-word model of the selected function, checked whenever a result is presented.
    always @(negedge clk) begin : cmp
        logic [15:0] u, v, ef;
        logic [16:0] sm, s0, t;
        logic        eovf;
        if (out_valid === 1'b1) begin
            u  = op_a | (op_b & {16{op_s[0]}}) | (~op_b & {16{op_s[1]}});
            v  = (op_a & op_b & {16{op_s[3]}}) | (op_a & ~op_b & {16{op_s[2]}});
            sm = {1'b0, u} + {1'b0, v} + {16'd0, op_cin};
            s0 = {1'b0, u} + {1'b0, v};
            t  = {2'b0, u[14:0]} + {2'b0, v[14:0]} + {16'd0, op_cin};
            ef = op_m ? ~(u ^ v) : sm[15:0];
`ifdef ALU181_OVF_EN
            eovf = ~op_m & (t[15] ^ sm[16]);
`else
            eovf = 1'b0;
`endif
            chk("m_f", f_o, ef);
            chk("m_cout", cout_o, op_m ? 1'b0 : sm[16]);
            chk("m_aeqb", aeqb_o, &ef);
            chk("m_grp_p", grp_p_o, &u);
            chk("m_grp_g", grp_g_o, s0[16]);
            chk("m_ovf", ovf_o, eovf);
            chk("m_in_ready", in_ready, 1'b0);
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
        int lat;
        op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
        chk("accept_ready", in_ready, 1'b1);
        a_i = a; b_i = b; s_i = s; m_i = m; cin_i = cin; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", lat, 4);
    endtask

    task automatic release_op(input int hold, input logic inject);
        repeat (hold) begin
            @(posedge clk);
            #1 chk("bp_valid", out_valid, 1'b1);
            chk("bp_ready", in_ready, 1'b0);
            if (inject) begin
                a_i = 16'hAAAA; b_i = 16'h5555; s_i = 4'h0; m_i = 1; cin_i = 1; in_valid = 1;
            end
        end
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        chk("rel_valid", out_valid, 1'b0);
        chk("rel_ready", in_ready, 1'b1);
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0;
        a_i = 0; b_i = 0; s_i = 0; m_i = 0; cin_i = 0;
        op_a = 0; op_b = 0; op_s = 0; op_m = 0; op_cin = 0;
        @(posedge clk);
        #1;
        chk("rst_f", f_o, 16'h0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_flags", {cout_o, aeqb_o, grp_p_o, grp_g_o, ovf_o}, 5'b0);
        rst = 0;
        @(posedge clk);
        #1;

        run_op(16'h1234, 16'h0FFF, 4'd9, 1'b0, 1'b0);
        chk("add_f", f_o, 16'h2233);
        chk("add_cout", cout_o, 1'b0);
        release_op(0, 1'b0);

        run_op(16'h0005, 16'h0007, 4'd6, 1'b0, 1'b1);
        chk("sub_f", f_o, 16'hFFFE);
        chk("sub_cout", cout_o, 1'b0);
        release_op(0, 1'b0);

        run_op(16'h1234, 16'h1234, 4'd6, 1'b0, 1'b0);
        chk("subm1_f", f_o, 16'hFFFF);
        chk("subm1_aeqb", aeqb_o, 1'b1);
        release_op(0, 1'b0);

        run_op(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0);
        chk("xor_f", f_o, 16'h0FF0);
        chk("xor_cout", cout_o, 1'b0);
        chk("xor_aeqb", aeqb_o, 1'b0);
        release_op(0, 1'b0);

        run_op(16'hF0F0, 16'hFF00, 4'd3, 1'b1, 1'b0);
        chk("zero_f", f_o, 16'h0000);
        release_op(0, 1'b0);

        run_op(16'hFFFF, 16'h0000, 4'd9, 1'b0, 1'b1);
        chk("wrap_f", f_o, 16'h0000);
        chk("wrap_cout", cout_o, 1'b1);
        chk("wrap_grp_p", grp_p_o, 1'b1);
        chk("wrap_grp_g", grp_g_o, 1'b0);
        release_op(3, 1'b1);

`ifdef ALU181_OVF_EN
        run_op(16'h7FFF, 16'h0001, 4'd9, 1'b0, 1'b0);
        chk("ovf_f", f_o, 16'h8000);
        chk("ovf_flag", ovf_o, 1'b1);
        release_op(0, 1'b0);
`endif

        run_op(16'h0100, 16'h1234, 4'd15, 1'b0, 1'b0);
        chk("dec_f", f_o, 16'h00FF);
        release_op(0, 1'b0);

        run_op(16'h3C5A, 16'h0FF0, 4'd11, 1'b1, 1'b0);
        chk("and_f", f_o, 16'h0C50);
        release_op(0, 1'b0);

        // abort an op two cycles into RUN
        a_i = 16'hFFFF; b_i = 16'h0000; s_i = 4'd9; m_i = 0; cin_i = 1; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("arst_f", f_o, 16'h0000);
        chk("arst_flags", {cout_o, aeqb_o, grp_p_o, grp_g_o, ovf_o}, 5'b0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;

        run_op(16'h00FF, 16'h0001, 4'd9, 1'b0, 1'b0);
        chk("post_rst_f", f_o, 16'h0100);
        chk("post_rst_cout", cout_o, 1'b0);
        release_op(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
